// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg
// Shared types and constants for the two-master AXI read arbiter.
//   ARB_ID_W / ARB_ADDR_W : default per-master ID and address widths
//   MST_CPU / MST_FB      : master indices, which form the MSB of the downstream ID
//   arState_e             : AR holding register occupancy
//   ar_req_t              : one captured AR request
package axi_rd_arb_pkg;

    localparam int ARB_ID_W   = 5;
    localparam int ARB_ADDR_W = 32;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_FB  = 1'b1;

    typedef enum logic {
        AR_EMPTY = 1'b0,
        AR_FULL  = 1'b1
    } arState_e;

    typedef struct packed {
        logic [ARB_ID_W-1:0]   id;
        logic [ARB_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_req_t;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// rr_arb2
// Two-request round-robin grant logic with a pointer flop.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   req_i[1:0]    : requests (already gated by the caller)
//   prio1_i       : when set and req_i[1] is set, master 1 wins outright
//   advance_i     : a grant was taken this cycle; move the pointer
//   gnt_o[1:0]    : one-hot grant, or zero when nothing is requested
module rr_arb2
    import axi_rd_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [1:0] req_i,
    input  logic       prio1_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic lastGrant_q;
    logic lastGrant_d;

    // With both requesting, the master that did not win last time goes next.
    always_comb begin
        gnt_o = 2'b00;
        if (prio1_i && req_i[1]) begin
            gnt_o = 2'b10;
        end else if (req_i == 2'b11) begin
            gnt_o = (lastGrant_q == MST_FB) ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

    // The pointer follows every taken grant, urgent ones included.
    always_comb begin
        lastGrant_d = lastGrant_q;
        if (advance_i && (gnt_o != 2'b00)) begin
            lastGrant_d = gnt_o[1];
        end
    end

    // Resetting to master 1 lets master 0 win the first contested slot.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lastGrant_q <= MST_FB;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Two-master round-robin arbiter for the AXI AR/R channels in front of the
// DDR port. AR requests are granted one at a time into a single holding
// register; the master index is prepended to the ID. R beats are routed back
// combinationally by the ID MSB. Per-master outstanding-burst counters
// throttle each master to MAX_OUTST in-flight reads.
//   clk, rstn          : clock, asynchronous active-low reset
//   s0_ar*, s1_ar*     : upstream AR channels (CPU = 0, framebuffer DMA = 1)
//   s0_r*, s1_r*       : upstream R channels (payload broadcast, valid routed)
//   m_ar*              : downstream AR channel, ID is {master, s_arid}
//   m_r*               : downstream R channel
//   s1_urgent          : framebuffer underrun warning
//   o_err              : sticky error, last beat returned to an idle master
// Optional feature: define AXI_RD_ARB_URGENT_EN to let s1_urgent give master 1
// absolute priority; otherwise s1_urgent is ignored.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int ID_W      = ARB_ID_W,
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ID_W-1:0]   s0_arid,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [7:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    input  logic [ID_W-1:0]   s1_arid,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [7:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [ID_W-1:0]   s0_rid,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    output logic [ID_W-1:0]   s1_rid,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [ID_W:0]     m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W:0]     m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic              s1_urgent,
    output logic              o_err
);

    localparam int              CNT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    arState_e         state_q, state_d;
    ar_req_t          req_q, req_d;
    logic             heldMst_q, heldMst_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             err_q, err_d;

    logic [1:0] eligible;
    logic [1:0] arbReq;
    logic [1:0] grant;
    logic       capture;
    logic       urgent;
    logic       rSel;
    logic       rDone;
    logic       dec0, dec1;

`ifdef AXI_RD_ARB_URGENT_EN
    assign urgent = s1_urgent;
`else
    logic unusedUrgent;
    assign urgent       = 1'b0;
    assign unusedUrgent = s1_urgent;
`endif

    // Saturating up/down count; simultaneous inc and dec cancel out.
    function automatic logic [CNT_W-1:0] cntNext(input logic [CNT_W-1:0] c,
                                                 input logic inc, input logic dec);
        if (inc && !dec) begin
            return c + CNT_W'(1);
        end else if (dec && !inc && (c != '0)) begin
            return c - CNT_W'(1);
        end
        return c;
    endfunction

    assign eligible[0] = s0_arvalid && (cnt0_q < CNT_MAX);
    assign eligible[1] = s1_arvalid && (cnt1_q < CNT_MAX);

    // Arbitration only runs while the holding register can take a request.
    assign arbReq  = (state_q == AR_EMPTY) ? eligible : 2'b00;
    assign capture = (grant != 2'b00);

    rr_arb2 u_rrArb (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .req_i    (arbReq),
        .prio1_i  (urgent),
        .advance_i(capture),
        .gnt_o    (grant)
    );

    assign s0_arready = grant[0];
    assign s1_arready = grant[1];

    // Holding register: capture from EMPTY, drain from FULL, never both at once.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        heldMst_d = heldMst_q;
        unique case (state_q)
            AR_EMPTY: begin
                if (capture) begin
                    state_d   = AR_FULL;
                    heldMst_d = grant[1];
                    if (grant[1]) begin
                        req_d = '{id: s1_arid, addr: s1_araddr, len: s1_arlen,
                                  size: s1_arsize, burst: s1_arburst};
                    end else begin
                        req_d = '{id: s0_arid, addr: s0_araddr, len: s0_arlen,
                                  size: s0_arsize, burst: s0_arburst};
                    end
                end
            end
            AR_FULL: begin
                if (m_arready) begin
                    state_d = AR_EMPTY;
                end
            end
            default: state_d = AR_EMPTY;
        endcase
    end

    assign m_arvalid = (state_q == AR_FULL);
    assign m_arid    = {heldMst_q, req_q.id};
    assign m_araddr  = req_q.addr;
    assign m_arlen   = req_q.len;
    assign m_arsize  = req_q.size;
    assign m_arburst = req_q.burst;

    // R path is pure wiring: the ID MSB selects which master sees valid/ready.
    assign rSel      = m_rid[ID_W];
    assign s0_rvalid = m_rvalid && (rSel == MST_CPU);
    assign s1_rvalid = m_rvalid && (rSel == MST_FB);
    assign m_rready  = (rSel == MST_FB) ? s1_rready : s0_rready;
    assign s0_rid    = m_rid[ID_W-1:0];
    assign s1_rid    = m_rid[ID_W-1:0];
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rlast  = m_rlast;

    // A burst retires on its accepted last beat; a retire with nothing
    // outstanding is a protocol error that sticks until reset.
    assign rDone = m_rvalid && m_rready && m_rlast;
    assign dec0  = rDone && (rSel == MST_CPU);
    assign dec1  = rDone && (rSel == MST_FB);

    always_comb begin
        cnt0_d = cntNext(cnt0_q, grant[0], dec0);
        cnt1_d = cntNext(cnt1_q, grant[1], dec1);
        err_d  = err_q || (dec0 && (cnt0_q == '0)) || (dec1 && (cnt1_q == '0));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= AR_EMPTY;
            req_q     <= '0;
            heldMst_q <= MST_CPU;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            heldMst_q <= heldMst_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            err_q     <= err_d;
        end
    end

    assign o_err = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
// Self-checking bench for axi_rd_arbiter: a cycle-level behavioural model
// (holding-register occupancy, per-master in-flight counts, sticky error)
// predicts every output; directed sequences and a routing table cover the
// corner cases, then a randomized run with a mid-run reset.
// Honours AXI_RD_ARB_URGENT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    localparam int ID_W      = 5;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int MAX_OUTST = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic [ID_W-1:0]   s0_arid, s1_arid;
    logic [ADDR_W-1:0] s0_araddr, s1_araddr;
    logic [7:0]        s0_arlen, s1_arlen;
    logic [2:0]        s0_arsize, s1_arsize;
    logic [1:0]        s0_arburst, s1_arburst;
    logic              s0_arvalid, s1_arvalid;
    logic              s0_arready, s1_arready;
    logic [ID_W-1:0]   s0_rid, s1_rid;
    logic [DATA_W-1:0] s0_rdata, s1_rdata;
    logic [1:0]        s0_rresp, s1_rresp;
    logic              s0_rlast, s1_rlast;
    logic              s0_rvalid, s1_rvalid;
    logic              s0_rready, s1_rready;
    logic [ID_W:0]     m_arid;
    logic [ADDR_W-1:0] m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid, m_arready;
    logic [ID_W:0]     m_rid;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast, m_rvalid, m_rready;
    logic              s1_urgent;
    logic              o_err;

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s1_urgent(s1_urgent), .o_err(o_err)
    );

    typedef struct {
        logic              v0, v1;
        logic [ID_W-1:0]   id0, id1;
        logic [ADDR_W-1:0] a0, a1;
        logic [7:0]        l0, l1;
        logic [2:0]        sz0, sz1;
        logic [1:0]        bu0, bu1;
        logic              marready;
        logic              rvalid;
        logic [ID_W:0]     rid;
        logic              rlast;
        logic              rr0, rr1;
        logic              urgent;
    } stim_t;

    typedef struct {
        logic sel, rvalid, rr0, rr1;
        logic expS0v, expS1v, expMready;
    } route_t;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit                mFull;
    logic [ID_W:0]     mId;
    logic [ADDR_W-1:0] mAddr;
    logic [7:0]        mLen;
    logic [2:0]        mSize;
    logic [1:0]        mBurst;
    int                mLast;
    int                mCnt [2];
    bit                mErr;
    int                expWinner;

    int grantLog [$];
    bit autoReturn = 1'b0;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mFull  = 1'b0;
        mId    = '0;
        mAddr  = '0;
        mLen   = '0;
        mSize  = '0;
        mBurst = '0;
        mLast  = 1;
        mCnt[0] = 0;
        mCnt[1] = 0;
        mErr   = 1'b0;
    endtask

    function automatic stim_t mkStim(input logic v0, input logic v1, input logic rdy);
        stim_t s;
        s.v0 = v0;            s.v1 = v1;
        s.id0 = ID_W'($urandom); s.id1 = ID_W'($urandom);
        s.a0 = $urandom;      s.a1 = $urandom;
        s.l0 = 8'($urandom);  s.l1 = 8'($urandom);
        s.sz0 = 3'($urandom); s.sz1 = 3'($urandom);
        s.bu0 = 2'($urandom); s.bu1 = 2'($urandom);
        s.marready = rdy;
        s.rvalid = 1'b0;      s.rid = '0;  s.rlast = 1'b0;
        s.rr0 = 1'b1;         s.rr1 = 1'b1;
        s.urgent = 1'b0;
        return s;
    endfunction

    // Drive one cycle of inputs; autoReturn retires the held burst while it drains.
    task automatic driveStim(input stim_t sIn, output stim_t sOut);
        sOut = sIn;
        if (autoReturn) begin
            sOut.rvalid = mFull;
            sOut.rlast  = mFull;
            sOut.rid    = mId;
            sOut.rr0    = 1'b1;
            sOut.rr1    = 1'b1;
        end
        s0_arvalid = sOut.v0;  s1_arvalid = sOut.v1;
        s0_arid    = sOut.id0; s1_arid    = sOut.id1;
        s0_araddr  = sOut.a0;  s1_araddr  = sOut.a1;
        s0_arlen   = sOut.l0;  s1_arlen   = sOut.l1;
        s0_arsize  = sOut.sz0; s1_arsize  = sOut.sz1;
        s0_arburst = sOut.bu0; s1_arburst = sOut.bu1;
        m_arready  = sOut.marready;
        m_rvalid   = sOut.rvalid;
        m_rid      = sOut.rid;
        m_rlast    = sOut.rlast;
        s0_rready  = sOut.rr0;
        s1_rready  = sOut.rr1;
        s1_urgent  = sOut.urgent;
        m_rdata    = {$urandom, $urandom};
        m_rresp    = 2'($urandom);
    endtask

    // Predict outputs from the arbitration rules and compare.
    task automatic checkOutput(input stim_t t);
        bit e0, e1, urgOn, sel;
        e0 = t.v0 && (mCnt[0] < MAX_OUTST);
        e1 = t.v1 && (mCnt[1] < MAX_OUTST);
        urgOn = 1'b0;
`ifdef AXI_RD_ARB_URGENT_EN
        urgOn = 1'b1;
`endif
        expWinner = -1;
        if (!mFull) begin
            if (urgOn && t.urgent && e1) expWinner = 1;
            else if (e0 && e1)          expWinner = 1 - mLast;
            else if (e0)                expWinner = 0;
            else if (e1)                expWinner = 1;
        end
        sel = t.rid[ID_W];
        checkVal("s0_arready", s0_arready, 64'(expWinner == 0));
        checkVal("s1_arready", s1_arready, 64'(expWinner == 1));
        checkVal("m_arvalid",  m_arvalid,  64'(mFull));
        checkVal("m_arid",     m_arid,     64'(mId));
        checkVal("m_araddr",   m_araddr,   64'(mAddr));
        checkVal("m_arlen",    m_arlen,    64'(mLen));
        checkVal("m_arsize",   m_arsize,   64'(mSize));
        checkVal("m_arburst",  m_arburst,  64'(mBurst));
        checkVal("s0_rvalid",  s0_rvalid,  64'(t.rvalid && !sel));
        checkVal("s1_rvalid",  s1_rvalid,  64'(t.rvalid && sel));
        checkVal("m_rready",   m_rready,   64'(sel ? t.rr1 : t.rr0));
        checkVal("s0_rdata",   s0_rdata,   m_rdata);
        checkVal("s1_rdata",   s1_rdata,   m_rdata);
        checkVal("s1_rid",     s1_rid,     64'(t.rid[ID_W-1:0]));
        checkVal("s0_rresp",   s0_rresp,   64'(m_rresp));
        checkVal("s1_rlast",   s1_rlast,   64'(t.rlast));
        checkVal("o_err",      o_err,      64'(mErr));
        if (s0_arready) grantLog.push_back(0);
        if (s1_arready) grantLog.push_back(1);
    endtask

    // Advance the model across the coming rising edge.
    task automatic modelStep(input stim_t t);
        bit done, sel;
        int inc [2];
        int d;
        sel = t.rid[ID_W];
        done = t.rvalid && (sel ? t.rr1 : t.rr0) && t.rlast;
        inc[0] = 0;
        inc[1] = 0;
        if (mFull) begin
            if (t.marready) mFull = 1'b0;
        end else if (expWinner >= 0) begin
            mFull = 1'b1;
            mLast = expWinner;
            inc[expWinner] = 1;
            if (expWinner == 1) begin
                mId = {1'b1, t.id1}; mAddr = t.a1; mLen = t.l1; mSize = t.sz1; mBurst = t.bu1;
            end else begin
                mId = {1'b0, t.id0}; mAddr = t.a0; mLen = t.l0; mSize = t.sz0; mBurst = t.bu0;
            end
        end
        for (int x = 0; x < 2; x++) begin
            d = (done && (int'(sel) == x)) ? 1 : 0;
            if (d == 1 && mCnt[x] == 0) mErr = 1'b1;
            mCnt[x] = mCnt[x] + inc[x] - d;
            if (mCnt[x] < 0) mCnt[x] = 0;
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        stim_t t;
        driveStim(s, t);
        #1;
        checkOutput(t);
        modelStep(t);
        @(negedge clk);
    endtask

    // Assert reset (takes effect at once), check reset values, hold over an edge.
    task automatic doReset();
        stim_t t;
        autoReturn = 1'b0;
        rstn = 1'b0;
        driveStim(mkStim(1'b0, 1'b0, 1'b0), t);
        #1;
        checkVal("rst_m_arvalid",  m_arvalid,  64'd0);
        checkVal("rst_s0_arready", s0_arready, 64'd0);
        checkVal("rst_s1_arready", s1_arready, 64'd0);
        checkVal("rst_m_arid",     m_arid,     64'd0);
        checkVal("rst_m_araddr",   m_araddr,   64'd0);
        checkVal("rst_m_arlen",    m_arlen,    64'd0);
        checkVal("rst_o_err",      o_err,      64'd0);
        modelReset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    route_t routeTbl [8];

    initial begin
        stim_t s;
        int beat, zeros, g;
        int urgExp [3];

        routeTbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        routeTbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        routeTbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        routeTbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        routeTbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        routeTbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        routeTbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        routeTbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef AXI_RD_ARB_URGENT_EN
        urgExp = '{1, 1, 1};
`else
        urgExp = '{1, 0, 1};
`endif

        rstn = 1'b0;
        @(negedge clk);

        // Both request from reset: master 0 first, master 1 next
        doReset();
        grantLog.delete();
        for (int i = 0; i < 4; i++) applyStimulus(mkStim(1'b1, 1'b1, 1'b1));
        checkVal("first_grant_cnt", 64'(grantLog.size()), 64'd2);
        g = (grantLog.size() > 0) ? grantLog[0] : -1;
        checkVal("first_grant_0", 64'(g), 64'd0);
        g = (grantLog.size() > 1) ? grantLog[1] : -1;
        checkVal("first_grant_1", 64'(g), 64'd1);

        // Fairness: 20 grants, strictly alternating
        doReset();
        autoReturn = 1'b1;
        grantLog.delete();
        for (int i = 0; i < 40; i++) applyStimulus(mkStim(1'b1, 1'b1, 1'b1));
        autoReturn = 1'b0;
        checkVal("fair_grants", 64'(grantLog.size()), 64'd20);
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            g = (i < grantLog.size()) ? grantLog[i] : -1;
            if (g == 0) zeros++;
            checkVal($sformatf("fair_order_%0d", i), 64'(g), 64'(i % 2));
        end
        checkVal("fair_m0_count", 64'(zeros), 64'd10);

        // Throttle: 8 grants without returns, then one rlast frees one slot
        doReset();
        grantLog.delete();
        for (int i = 0; i < 30; i++) applyStimulus(mkStim(1'b1, 1'b0, 1'b1));
        checkVal("throttle_grants", 64'(grantLog.size()), 64'd8);
        s = mkStim(1'b1, 1'b0, 1'b1);
        s.rvalid = 1'b1; s.rlast = 1'b1; s.rid = {1'b0, 5'h07};
        applyStimulus(s);
        for (int i = 0; i < 10; i++) applyStimulus(mkStim(1'b1, 1'b0, 1'b1));
        checkVal("throttle_after_rlast", 64'(grantLog.size()), 64'd9);

        // R routing table, no rlast so counts are unaffected
        for (int i = 0; i < 8; i++) begin
            stim_t t;
            s = mkStim(1'b0, 1'b0, 1'b0);
            s.rid    = {routeTbl[i].sel, ID_W'($urandom)};
            s.rvalid = routeTbl[i].rvalid;
            s.rr0    = routeTbl[i].rr0;
            s.rr1    = routeTbl[i].rr1;
            driveStim(s, t);
            #1;
            checkVal($sformatf("tbl%0d_s0_rvalid", i), s0_rvalid, 64'(routeTbl[i].expS0v));
            checkVal($sformatf("tbl%0d_s1_rvalid", i), s1_rvalid, 64'(routeTbl[i].expS1v));
            checkVal($sformatf("tbl%0d_m_rready", i),  m_rready,  64'(routeTbl[i].expMready));
            checkOutput(t);
            modelStep(t);
            @(negedge clk);
        end

        // 4-beat burst to master 1 with toggling rready, then a stray rlast
        doReset();
        applyStimulus(mkStim(1'b0, 1'b1, 1'b1));
        applyStimulus(mkStim(1'b0, 1'b1, 1'b0));
        applyStimulus(mkStim(1'b0, 1'b0, 1'b1));
        beat = 0;
        for (int c = 0; c < 20 && beat < 4; c++) begin
            s = mkStim(1'b0, 1'b0, 1'b0);
            s.rvalid = 1'b1; s.rid = {1'b1, 5'h03}; s.rlast = (beat == 3);
            s.rr1 = c[0]; s.rr0 = 1'b1;
            applyStimulus(s);
            if (s.rr1) beat++;
        end
        checkVal("burst_beats", 64'(beat), 64'd4);
        checkVal("burst_no_err", o_err, 64'd0);
        s = mkStim(1'b0, 1'b0, 1'b0);
        s.rvalid = 1'b1; s.rid = {1'b1, 5'h03}; s.rlast = 1'b1;
        applyStimulus(s);
        for (int i = 0; i < 3; i++) applyStimulus(mkStim(1'b0, 1'b0, 1'b0));
        checkVal("stray_err_sticky", o_err, 64'd1);

        // Capture and rlast for master 0 in the same cycle
        doReset();
        applyStimulus(mkStim(1'b1, 1'b0, 1'b1));
        applyStimulus(mkStim(1'b0, 1'b0, 1'b1));
        s = mkStim(1'b1, 1'b0, 1'b1);
        s.rvalid = 1'b1; s.rlast = 1'b1; s.rid = {1'b0, 5'h11};
        applyStimulus(s);
        applyStimulus(mkStim(1'b0, 1'b0, 1'b1));
        s = mkStim(1'b0, 1'b0, 1'b0);
        s.rvalid = 1'b1; s.rlast = 1'b1; s.rid = {1'b0, 5'h11};
        applyStimulus(s);
        checkVal("same_cycle_no_err", o_err, 64'd0);
        applyStimulus(s);
        checkVal("same_cycle_err", o_err, 64'd1);

        // Urgent: last grant to master 0, both request with s1_urgent high
        doReset();
        autoReturn = 1'b1;
        applyStimulus(mkStim(1'b1, 1'b0, 1'b1));
        applyStimulus(mkStim(1'b1, 1'b0, 1'b1));
        grantLog.delete();
        for (int i = 0; i < 6; i++) begin
            s = mkStim(1'b1, 1'b1, 1'b1);
            s.urgent = 1'b1;
            applyStimulus(s);
        end
        autoReturn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            g = (i < grantLog.size()) ? grantLog[i] : -1;
            checkVal($sformatf("urgent_slot_%0d", i), 64'(g), 64'(urgExp[i]));
        end

        // Randomized traffic with a reset in the middle
        doReset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) doReset();
            s = mkStim($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 1) == 1);
            s.rvalid = $urandom_range(0, 1) == 1;
            s.rlast  = $urandom_range(0, 3) == 0;
            if (mCnt[0] > 0 && mCnt[1] > 0) s.rid = {1'($urandom), ID_W'($urandom)};
            else if (mCnt[1] > 0)           s.rid = {1'b1, ID_W'($urandom)};
            else if (mCnt[0] > 0)           s.rid = {1'b0, ID_W'($urandom)};
            else                            s.rid = {1'($urandom), ID_W'($urandom)};
            if ($urandom_range(0, 19) == 0) s.rid[ID_W] = ~s.rid[ID_W];
            s.rr0    = $urandom_range(0, 3) != 0;
            s.rr1    = $urandom_range(0, 3) != 0;
            s.urgent = $urandom_range(0, 2) == 0;
            applyStimulus(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
